// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch datapath: FSM encoding, BCD digit geometry
// and the field offsets of the packed MM:SS.cc display word.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } sw_state_e;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 6;
  localparam int DIGITS_W   = DIGIT_W * NUM_DIGITS;

  localparam logic [DIGIT_W-1:0] DEC_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] SEX_MAX = 4'd5;

  // Packed word is {min_t, min_o, sec_t, sec_o, cs_t, cs_o}
  localparam int CS_O_OFS  = 0;
  localparam int CS_T_OFS  = 4;
  localparam int SEC_O_OFS = 8;
  localparam int SEC_T_OFS = 12;
  localparam int MIN_O_OFS = 16;
  localparam int MIN_T_OFS = 20;

  localparam int SEC_T_IDX = SEC_T_OFS / DIGIT_W;

  // Rollover value of the digit at position idx (0 = cs_o ... 5 = min_t)
  function automatic logic [DIGIT_W-1:0] digit_limit(input int idx);
    return (idx == SEC_T_IDX) ? SEX_MAX : DEC_MAX;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV tick generator; holds its phase while en is low so
// a paused timebase resumes exactly where it stopped.
module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sync_clr,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sync_clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = en && (cnt_q == LAST);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch: run/pause/lap/clear FSM over a 6-digit BCD MM:SS.cc counter driven by
// a prescaled tick, with lap freeze and wrap-or-saturate behaviour at the limit.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 100,
  parameter int MAX_MIN  = 59,
  parameter int SATURATE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_mode_en,
  input  logic        i_run_tgl,
  input  logic        i_lap,
  input  logic        i_clear,
  output logic [23:0] o_digits,
  output logic        o_running,
  output logic        o_lap,
  output logic        o_tick,
  output logic        o_overflow
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  function automatic logic [DIGITS_W-1:0] limit_value();
    logic [DIGITS_W-1:0] v;
    v = '0;
    v[MIN_T_OFS +: DIGIT_W] = DIGIT_W'(MAX_MIN / 10);
    v[MIN_O_OFS +: DIGIT_W] = DIGIT_W'(MAX_MIN % 10);
    v[SEC_T_OFS +: DIGIT_W] = SEX_MAX;
    v[SEC_O_OFS +: DIGIT_W] = DEC_MAX;
    v[CS_T_OFS  +: DIGIT_W] = DEC_MAX;
    v[CS_O_OFS  +: DIGIT_W] = DEC_MAX;
    return v;
  endfunction

  localparam logic [DIGITS_W-1:0] LIMIT = limit_value();

  // Ripple-carry increment of the BCD word; only used below the limit, so the
  // minute pair never has to honour MAX_MIN itself.
  function automatic logic [DIGITS_W-1:0] bcd_inc(input logic [DIGITS_W-1:0] c);
    logic [DIGITS_W-1:0] r;
    logic carry;
    r = c;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if ((i < NUM_DIGITS - 1) && (r[i*DIGIT_W +: DIGIT_W] == digit_limit(i))) begin
          r[i*DIGIT_W +: DIGIT_W] = '0;
        end else begin
          r[i*DIGIT_W +: DIGIT_W] = r[i*DIGIT_W +: DIGIT_W] + 1'b1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  sw_state_e state_q, state_d;
  logic [DIGITS_W-1:0] count_q, count_d;
  logic [DIGITS_W-1:0] lap_q, lap_d;
  logic [DIGITS_W-1:0] digits_q, digits_d;
  logic running_q, running_d;
  logic lap_flag_q, lap_flag_d;
  logic ovf_q, ovf_d;

  logic tick;
  logic pre_en;
  logic pre_clr;
  logic at_limit;

  assign pre_en   = i_mode_en && ((state_q == ST_RUN) || (state_q == ST_LAP));
  assign at_limit = (count_q == LIMIT);

  tick_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .en      (pre_en),
    .sync_clr(pre_clr),
    .o_tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lap_d   = lap_q;
    ovf_d   = 1'b0;
    pre_clr = 1'b0;

    if (i_mode_en) begin
      if (tick) begin
        if (at_limit) begin
          ovf_d = 1'b1;
          if (SATURATE == 0) begin
            count_d = '0;
          end
        end else begin
          count_d = bcd_inc(count_q);
        end
      end

      // Lap captures the registered count, never the value a same-cycle tick produces
      case (state_q)
        ST_IDLE: begin
          if (i_run_tgl) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (i_run_tgl) begin
            state_d = ST_PAUSE;
          end else if (i_lap) begin
            state_d = ST_LAP;
            lap_d   = count_q;
          end
        end
        ST_LAP: begin
          if (i_run_tgl) begin
            state_d = ST_PAUSE;
          end else if (i_lap) begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (i_clear) begin
            state_d = ST_IDLE;
            count_d = '0;
            lap_d   = '0;
            pre_clr = 1'b1;
          end else if (i_run_tgl) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Hitting the limit in saturate mode overrides any button in the same cycle
      if ((SATURATE != 0) && tick && at_limit) begin
        state_d = ST_PAUSE;
      end
    end

    digits_d   = (state_d == ST_LAP) ? lap_d : count_d;
    running_d  = (state_d == ST_RUN) || (state_d == ST_LAP);
    lap_flag_d = (state_d == ST_LAP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      lap_q      <= '0;
      digits_q   <= '0;
      running_q  <= 1'b0;
      lap_flag_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      lap_q      <= lap_d;
      digits_q   <= digits_d;
      running_q  <= running_d;
      lap_flag_q <= lap_flag_d;
      ovf_q      <= ovf_d;
    end
  end

  assign o_digits   = digits_q;
  assign o_running  = running_q;
  assign o_lap      = lap_flag_q;
  assign o_tick     = tick;
  assign o_overflow = ovf_q;

endmodule
